// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the add/sub sequencer state encoding.
// Encoding 2'd3 is unused; the sequencer treats it as IDLE.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/addsub_slice.sv
// Combinational W-bit ripple slice of the iterative adder: {cout, sum} = a + b + cin.
module addsub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/alu_addsub_iter.sv
// Multi-cycle 32-bit add/subtract: one SLICE_W-bit slice per cycle through a single shared
// slice adder, then registered result, carry-out and overflow/zero/slt flags with a valid/ready handshake.
module alu_addsub_iter
    import alu_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b_x,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            cout,
    output logic            ovf,
    output logic            zero,
    output logic            slt
);

    localparam int NSLICE = XLEN / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     b_q;
    logic                carry_q;
    logic [XLEN-1:0]     result_q;
    logic                cout_q;
    logic                ovf_q;
    logic                zero_q;
    logic                slt_q;
    logic                in_ready_q;
    logic                out_valid_q;

    int                  sliceBase;
    logic [SLICE_W-1:0]  sliceA;
    logic [SLICE_W-1:0]  sliceB;
    logic [SLICE_W-1:0]  sliceSum;
    logic                sliceCout;
    logic [XLEN-1:0]     result_d;
    logic                ovf_d;

    always_comb begin
        sliceBase = int'(cnt_q) * SLICE_W;
        sliceA    = a_q[sliceBase +: SLICE_W];
        sliceB    = b_q[sliceBase +: SLICE_W];
    end

    addsub_slice #(.W(SLICE_W)) uSlice (
        .a_i    (sliceA),
        .b_i    (sliceB),
        .cin_i  (carry_q),
        .sum_o  (sliceSum),
        .cout_o (sliceCout)
    );

    // Flags must see the final slice, so they are derived from the merged next-state result.
    always_comb begin
        result_d = result_q;
        result_d[sliceBase +: SLICE_W] = sliceSum;
        ovf_d = (a_q[XLEN-1] == b_q[XLEN-1]) && (result_d[XLEN-1] != a_q[XLEN-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            slt_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b_x;
                        carry_q    <= sub;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result_q <= result_d;
                    carry_q  <= sliceCout;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        cnt_q       <= '0;
                        cout_q      <= sliceCout;
                        ovf_q       <= ovf_d;
                        zero_q      <= ~|result_d;
                        slt_q       <= result_d[XLEN-1] ^ ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE first means in_valid is never taken in the handshake cycle.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign slt       = slt_q;

endmodule

// File: tb/tb_alu_addsub_iter.sv
// Bench for alu_addsub_iter: four instances (SLICE_W 8, 1, 4, 32) driven one at a time and
// compared against a plain-arithmetic reference of a + b_x + sub.
module tb_alu_addsub_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] aIn;
    logic [31:0] bIn;
    logic        subIn;
    logic        outReady;

    logic        inValid   [4];
    logic        inReady   [4];
    logic        outValid  [4];
    logic [31:0] resultArr [4];
    logic        coutArr   [4];
    logic        ovfArr    [4];
    logic        zeroArr   [4];
    logic        sltArr    [4];

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gDut
        localparam int W = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
        alu_addsub_iter #(.SLICE_W(W)) uDut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (inValid[g]),
            .in_ready  (inReady[g]),
            .a         (aIn),
            .b_x       (bIn),
            .sub       (subIn),
            .out_valid (outValid[g]),
            .out_ready (outReady),
            .result    (resultArr[g]),
            .cout      (coutArr[g]),
            .ovf       (ovfArr[g]),
            .zero      (zeroArr[g]),
            .slt       (sltArr[g])
        );
    end

    function automatic int sliceWidth(input int idx);
        case (idx)
            0:       return 8;
            1:       return 1;
            2:       return 4;
            default: return 32;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Unsigned 33-bit sum for result/cout; exact signed sum for overflow and less-than.
    task automatic refModel(input logic [31:0] a, input logic [31:0] b, input logic s,
                            output logic [31:0] res, output logic co, output logic ov,
                            output logic ze, output logic lt);
        logic [32:0] wide;
        longint      sSum;
        wide = {1'b0, a} + {1'b0, b} + 33'(s);
        sSum = longint'($signed(a)) + longint'($signed(b)) + longint'(s);
        res  = wide[31:0];
        co   = wide[32];
        ov   = (sSum > 64'sd2147483647) || (sSum < -64'sd2147483648);
        ze   = (wide[31:0] == 32'd0);
        lt   = (sSum < 0);
    endtask

    task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input int holdCycles);
        int          guard;
        int          latency;
        int          nslice;
        logic [31:0] expRes;
        logic        expCout, expOvf, expZero, expSlt;

        nslice = 32 / sliceWidth(idx);
        refModel(a, b, s, expRes, expCout, expOvf, expZero, expSlt);

        guard = 0;
        @(negedge clk);
        while (!inReady[idx] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput($sformatf("d%0d in_ready idle", idx), 32'(inReady[idx]), 32'd1);

        aIn = a; bIn = b; subIn = s; inValid[idx] = 1'b1;
        @(posedge clk);
        #1;
        inValid[idx] = 1'b0;
        aIn = $urandom; bIn = $urandom; subIn = 1'($urandom_range(1));

        latency = 1;
        @(negedge clk);
        checkOutput($sformatf("d%0d in_ready run", idx), 32'(inReady[idx]), 32'd0);
        while (!outValid[idx] && latency < 100) begin
            @(posedge clk);
            latency++;
            @(negedge clk);
        end
        checkOutput($sformatf("d%0d latency", idx), 32'(latency), 32'(nslice + 1));
        checkOutput($sformatf("d%0d result", idx), resultArr[idx], expRes);
        checkOutput($sformatf("d%0d cout", idx), 32'(coutArr[idx]), 32'(expCout));
        checkOutput($sformatf("d%0d ovf", idx), 32'(ovfArr[idx]), 32'(expOvf));
        checkOutput($sformatf("d%0d zero", idx), 32'(zeroArr[idx]), 32'(expZero));
        checkOutput($sformatf("d%0d slt", idx), 32'(sltArr[idx]), 32'(expSlt));

        for (int h = 0; h < holdCycles; h++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("d%0d hold out_valid", idx), 32'(outValid[idx]), 32'd1);
            checkOutput($sformatf("d%0d hold in_ready", idx), 32'(inReady[idx]), 32'd0);
            checkOutput($sformatf("d%0d hold result", idx), resultArr[idx], expRes);
        end

        // in_valid is also high on the handshake edge; it must not be taken in DONE.
        outReady = 1'b1;
        inValid[idx] = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        inValid[idx] = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("d%0d in_ready after", idx), 32'(inReady[idx]), 32'd1);
        checkOutput($sformatf("d%0d out_valid after", idx), 32'(outValid[idx]), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        rst = 1'b1; outReady = 1'b0; aIn = '0; bIn = '0; subIn = 1'b0;
        for (int i = 0; i < 4; i++) inValid[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("d%0d reset in_ready", i), 32'(inReady[i]), 32'd1);
            checkOutput($sformatf("d%0d reset out_valid", i), 32'(outValid[i]), 32'd0);
            checkOutput($sformatf("d%0d reset result", i), resultArr[i], 32'd0);
        end

        applyStimulus(0, 32'd5, 32'd3, 1'b0, 0);
        applyStimulus(0, 32'd3, 32'hFFFFFFFA, 1'b1, 0);
        applyStimulus(0, 32'd7, 32'hFFFFFFF8, 1'b1, 1);
        applyStimulus(0, 32'h80000000, 32'hFFFFFFFE, 1'b1, 0);
        applyStimulus(0, 32'h7FFFFFFF, 32'd1, 1'b0, 3);

        // Abort an operation in its second RUN cycle; flags from the last op are still set.
        @(negedge clk);
        aIn = 32'h12345678; bIn = 32'h01010101; subIn = 1'b0; inValid[0] = 1'b1;
        @(posedge clk);
        #1 inValid[0] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst mid-run in_ready", 32'(inReady[0]), 32'd1);
        checkOutput("rst mid-run out_valid", 32'(outValid[0]), 32'd0);
        checkOutput("rst mid-run result", resultArr[0], 32'd0);
        checkOutput("rst mid-run cout", 32'(coutArr[0]), 32'd0);
        checkOutput("rst mid-run ovf", 32'(ovfArr[0]), 32'd0);
        checkOutput("rst mid-run zero", 32'(zeroArr[0]), 32'd0);
        checkOutput("rst mid-run slt", 32'(sltArr[0]), 32'd0);
        applyStimulus(0, 32'h12345678, 32'h01010101, 1'b0, 0);

        for (int d = 0; d < 4; d++) begin
            applyStimulus(d, 32'hFFFFFFFF, 32'd0, 1'b1, 0);
            for (int n = 0; n < 12; n++) begin
                ra = $urandom;
                rb = $urandom;
                rs = 1'($urandom_range(1));
                case ($urandom_range(3))
                    0: begin rb = ~ra; rs = 1'b1; end
                    1: ra = {ra[31], {31{ra[31] ? 1'b0 : 1'b1}}};
                    default: ;
                endcase
                applyStimulus(d, ra, rb, rs, int'($urandom_range(2)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
